// File: rtl/conv_pkg.sv
// Shared definitions for the convolution datapath: pixel width, kernel size,
// patch width and the patch_gen FSM state type.
package conv_pkg;

  localparam int DATA_W  = 16;
  localparam int KSIZE   = 3;
  localparam int PATCH_W = KSIZE * KSIZE * DATA_W;

  typedef logic [0:0] state_t;
  localparam state_t PRIME  = 1'b0;
  localparam state_t STREAM = 1'b1;

endpackage

// File: rtl/patch_gen_if.sv
// Pixel-in / patch-out handshake bundle for patch_gen. PATCH_ROW/PATCH_COL
// exist only when PATCH_GEN_POS_EN is defined.
interface patch_gen_if #(
  parameter int DATA_W = conv_pkg::DATA_W
);
  import conv_pkg::KSIZE;

  localparam int PW = KSIZE * KSIZE * DATA_W;

  logic              PIX_VALID;
  logic              PIX_READY;
  logic [DATA_W-1:0] PIX_DATA;
  logic              PATCH_VALID;
  logic              PATCH_READY;
  logic [PW-1:0]     PATCH;
  logic              FRAME_DONE;
`ifdef PATCH_GEN_POS_EN
  logic [15:0]       PATCH_ROW;
  logic [15:0]       PATCH_COL;

  // master: pixel source and patch sink; slave: patch_gen itself
  modport master (output PIX_VALID, PIX_DATA, PATCH_READY,
                  input  PIX_READY, PATCH_VALID, PATCH, FRAME_DONE, PATCH_ROW, PATCH_COL);
  modport slave  (input  PIX_VALID, PIX_DATA, PATCH_READY,
                  output PIX_READY, PATCH_VALID, PATCH, FRAME_DONE, PATCH_ROW, PATCH_COL);
`else
  modport master (output PIX_VALID, PIX_DATA, PATCH_READY,
                  input  PIX_READY, PATCH_VALID, PATCH, FRAME_DONE);
  modport slave  (input  PIX_VALID, PIX_DATA, PATCH_READY,
                  output PIX_READY, PATCH_VALID, PATCH, FRAME_DONE);
`endif

endinterface

// File: rtl/patch_gen_line_buf.sv
// line_buf: DEPTH-deep delay line advancing on accept. dout_o is the word written
// DEPTH accepts ago and is prefetched so it is ready before the next accept.
module line_buf #(
  parameter int DEPTH  = 8,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              adv_i,
  input  logic [DATA_W-1:0] din_i,
  output logic [DATA_W-1:0] dout_o
);

  localparam int AW = $clog2(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     ptr_q, ptr_d;
  logic [DATA_W-1:0] dout_q;

  assign ptr_d  = (ptr_q == AW'(DEPTH - 1)) ? '0 : ptr_q + 1'b1;
  assign dout_o = dout_q;

  always_ff @(posedge clk) begin
    if (adv_i) begin
      mem[ptr_q] <= din_i;
    end
  end

  // Reading the slot for the *next* accept keeps the read registered; it never
  // collides with the slot being written because DEPTH >= 3.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q  <= '0;
      dout_q <= '0;
    end else if (adv_i) begin
      ptr_q  <= ptr_d;
      dout_q <= mem[ptr_d];
    end
  end

endmodule

// File: rtl/patch_gen.sv
// patch_gen: raster pixel stream -> 3x3 "valid" convolution patches for conv.
// Optional centre-coordinate outputs PATCH_ROW/PATCH_COL under PATCH_GEN_POS_EN.
module patch_gen #(
  parameter int IMG_W  = 8,
  parameter int IMG_H  = 8,
  parameter int DATA_W = conv_pkg::DATA_W
) (
  input  logic       CLK,
  input  logic       rst,
  patch_gen_if.slave bus
);
  import conv_pkg::KSIZE;
  import conv_pkg::state_t;
  import conv_pkg::PRIME;
  import conv_pkg::STREAM;

  localparam int KK = KSIZE * KSIZE;
  localparam int PW = KK * DATA_W;
  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);

  logic [CW-1:0]     col_q, col_d;
  logic [RW-1:0]     row_q, row_d;
  state_t            state_q, state_d;
  logic [DATA_W-1:0] win_q [KK];
  logic [DATA_W-1:0] win_d [KK];
  logic [DATA_W-1:0] new_col [KSIZE];
  logic [DATA_W-1:0] up1, up2;
  logic [PW-1:0]     patch_q, patch_d;
  logic              patch_valid_q, patch_valid_d, frame_done_q;
  logic              pix_ready, accept, col_last, row_last, emit;

  assign pix_ready = !patch_valid_q || bus.PATCH_READY;
  assign accept    = bus.PIX_VALID && pix_ready;
  assign col_last  = (col_q == CW'(IMG_W - 1));
  assign row_last  = (row_q == RW'(IMG_H - 1));
  assign emit      = accept && (state_q == STREAM) && (col_q >= CW'(2));

  assign bus.PIX_READY   = pix_ready;
  assign bus.PATCH_VALID = patch_valid_q;
  assign bus.PATCH       = patch_q;
  assign bus.FRAME_DONE  = frame_done_q;

  line_buf #(.DEPTH(IMG_W), .DATA_W(DATA_W)) u_lb1 (
    .clk(CLK), .rst(rst), .adv_i(accept), .din_i(bus.PIX_DATA), .dout_o(up1)
  );
  line_buf #(.DEPTH(IMG_W), .DATA_W(DATA_W)) u_lb2 (
    .clk(CLK), .rst(rst), .adv_i(accept), .din_i(up1), .dout_o(up2)
  );

  assign new_col[0] = up2;
  assign new_col[1] = up1;
  assign new_col[2] = bus.PIX_DATA;

  // win index = row*KSIZE + col; each accept shifts left and inserts the new column.
  genvar gi;
  generate
    for (gi = 0; gi < KK; gi++) begin : g_win
      if ((gi % KSIZE) == KSIZE - 1) begin : g_new
        assign win_d[gi] = new_col[gi / KSIZE];
      end else begin : g_shift
        assign win_d[gi] = win_q[gi + 1];
      end
      assign patch_d[PW-1-gi*DATA_W -: DATA_W] = win_d[gi];
    end
  endgenerate

  always_comb begin
    col_d   = col_q;
    row_d   = row_q;
    state_d = state_q;
    if (accept) begin
      if (col_last) begin
        col_d = '0;
        row_d = row_last ? '0 : row_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end
      if (state_q == PRIME && row_q == RW'(1) && col_last) begin
        state_d = STREAM;
      end else if (state_q == STREAM && row_last && col_last) begin
        state_d = PRIME;
      end
    end
  end

  assign patch_valid_d = emit || (patch_valid_q && !bus.PATCH_READY);

  always_ff @(posedge CLK or posedge rst) begin
    if (rst) begin
      col_q         <= '0;
      row_q         <= '0;
      state_q       <= PRIME;
      patch_q       <= '0;
      patch_valid_q <= 1'b0;
      frame_done_q  <= 1'b0;
      for (int k = 0; k < KK; k++) begin
        win_q[k] <= '0;
      end
    end else begin
      col_q         <= col_d;
      row_q         <= row_d;
      state_q       <= state_d;
      patch_valid_q <= patch_valid_d;
      frame_done_q  <= accept && col_last && row_last;
      if (accept) begin
        for (int k = 0; k < KK; k++) begin
          win_q[k] <= win_d[k];
        end
      end
      if (emit) begin
        patch_q <= patch_d;
      end
    end
  end

`ifdef PATCH_GEN_POS_EN
  logic [15:0] patch_row_q, patch_col_q;

  always_ff @(posedge CLK or posedge rst) begin
    if (rst) begin
      patch_row_q <= '0;
      patch_col_q <= '0;
    end else if (emit) begin
      patch_row_q <= 16'(row_q) - 16'd1;
      patch_col_q <= 16'(col_q) - 16'd1;
    end
  end

  assign bus.PATCH_ROW = patch_row_q;
  assign bus.PATCH_COL = patch_col_q;
`endif

endmodule

// File: tb/tb_patch_gen.sv
// Self-checking bench for patch_gen (4x4 image): directed sequences for stall,
// frame boundary and reset, plus a randomized vector table against a window model.
`timescale 1ns/1ps
module tb_patch_gen;

  localparam int W  = 4;
  localparam int H  = 4;
  localparam int DW = 16;
  localparam int PW = 9 * DW;
  localparam int NP = (W - 2) * (H - 2);

  typedef struct {
    int frames;
    int vpct;
    int rpct;
    bit rand_px;
    int exp_patches;
    int exp_done;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  patch_gen_if #(.DATA_W(DW)) bus ();

  patch_gen #(.IMG_W(W), .IMG_H(H), .DATA_W(DW)) dut (
    .CLK(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int rpct = 100;
  int n_patch, n_done, first_rise;
  logic [PW-1:0] first_patch;
  logic prev_done = 1'b0;

  logic [DW-1:0] px_q[$];
  logic [PW-1:0] exp_q[$];
  logic [PW-1:0] last_q[$];
  logic [PW-1:0] got_q[$];
  int acc_cyc[$];
`ifdef PATCH_GEN_POS_EN
  int erow_q[$];
  int ecol_q[$];
`endif

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_vec(input string nm, input logic [PW-1:0] got, input logic [PW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  task automatic check_int(input string nm, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, got, exp);
    end
  endtask

  // Window whose top-left pixel value is b, for a frame holding b+index values.
  function automatic logic [PW-1:0] pk9(input int b);
    logic [PW-1:0] v = '0;
    for (int dr = 0; dr < 3; dr++)
      for (int dc = 0; dc < 3; dc++)
        v = {v[PW-DW-1:0], 16'(b + dr * W + dc)};
    return v;
  endfunction

  task automatic fill_px(input int frames, input bit rnd, input int base);
    px_q.delete();
    for (int i = 0; i < frames * W * H; i++)
      px_q.push_back(rnd ? 16'($urandom) : 16'(base + i));
  endtask

  // Reference: every interior centre (r,c) of each frame yields its 3x3 neighbourhood.
  task automatic model_stream();
    int nf;
    logic [PW-1:0] v;
    nf = px_q.size() / (W * H);
    for (int f = 0; f < nf; f++) begin
      for (int r = 1; r < H - 1; r++) begin
        for (int c = 1; c < W - 1; c++) begin
          v = '0;
          for (int dr = -1; dr <= 1; dr++)
            for (int dc = -1; dc <= 1; dc++)
              v = {v[PW-DW-1:0], px_q[f * W * H + (r + dr) * W + (c + dc)]};
          exp_q.push_back(v);
`ifdef PATCH_GEN_POS_EN
          erow_q.push_back(r);
          ecol_q.push_back(c);
`endif
        end
      end
      last_q.push_back(v);
    end
  endtask

  task automatic clear_stats();
    exp_q.delete();
    last_q.delete();
    got_q.delete();
    acc_cyc.delete();
`ifdef PATCH_GEN_POS_EN
    erow_q.delete();
    ecol_q.delete();
`endif
    n_patch    = 0;
    n_done     = 0;
    first_rise = -1;
  endtask

  task automatic set_ready(input int p);
    rpct = p;
    bus.PATCH_READY = (p >= 100);
  endtask

  task automatic send_stream(input int vpct);
    int guard;
    bit done;
    foreach (px_q[i]) begin
      while (int'($urandom_range(99)) >= vpct) begin
        bus.PIX_VALID = 1'b0;
        @(posedge clk); #1;
      end
      bus.PIX_VALID = 1'b1;
      bus.PIX_DATA  = px_q[i];
      guard = 0;
      done  = 1'b0;
      while (!done) begin
        @(negedge clk);
        if (bus.PIX_READY) begin
          acc_cyc.push_back(cyc + 1);
          done = 1'b1;
        end
        @(posedge clk); #1;
        guard++;
        if (!done && guard > 500) begin
          checks++;
          errors++;
          $display("FAIL pix_accept_timeout: pixel %0d not accepted in %0d cycles", i, guard);
          done = 1'b1;
        end
      end
      bus.PIX_VALID = 1'b0;
    end
  endtask

  task automatic drain();
    int g = 0;
    while ((exp_q.size() != 0 || bus.PATCH_VALID) && g < 400) begin
      @(posedge clk); #1;
      g++;
    end
    check_int("drain_done", int'(g < 400), 1);
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check_vec({tag, "_patch"}, bus.PATCH, '0);
    check_int({tag, "_patch_valid"}, int'(bus.PATCH_VALID), 0);
    check_int({tag, "_frame_done"}, int'(bus.FRAME_DONE), 0);
    check_int({tag, "_pix_ready"}, int'(bus.PIX_READY), 1);
`ifdef PATCH_GEN_POS_EN
    check_int({tag, "_patch_row"}, int'(bus.PATCH_ROW), 0);
    check_int({tag, "_patch_col"}, int'(bus.PATCH_COL), 0);
`endif
  endtask

  // Output monitor: scoreboard every accepted patch, frame-done placement.
  initial begin
    forever begin
      @(negedge clk);
      if (rst === 1'b0) begin
        if (bus.PATCH_VALID && first_rise < 0) begin
          first_rise  = cyc;
          first_patch = bus.PATCH;
        end
        if (bus.FRAME_DONE) begin
          n_done++;
          check_int("done_with_valid", int'(bus.PATCH_VALID), 1);
          check_int("done_one_cycle", int'(prev_done), 0);
          if (last_q.size() != 0) check_vec("done_last_patch", bus.PATCH, last_q.pop_front());
          else check_int("done_unexpected", 1, 0);
        end
        if (bus.PATCH_VALID && bus.PATCH_READY) begin
          n_patch++;
          got_q.push_back(bus.PATCH);
          if (exp_q.size() != 0) check_vec("patch", bus.PATCH, exp_q.pop_front());
          else check_int("patch_unexpected", 1, 0);
`ifdef PATCH_GEN_POS_EN
          if (erow_q.size() != 0) begin
            check_int("patch_row", int'(bus.PATCH_ROW), erow_q.pop_front());
            check_int("patch_col", int'(bus.PATCH_COL), ecol_q.pop_front());
          end
`endif
        end
        prev_done = bus.FRAME_DONE;
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk); #1;
      bus.PATCH_READY = (int'($urandom_range(99)) < rpct);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl [3];
    int rise_cyc;

    tbl[0] = '{frames: 1, vpct: 50, rpct: 100, rand_px: 1'b0, exp_patches: NP,     exp_done: 1};
    tbl[1] = '{frames: 2, vpct: 50, rpct: 60,  rand_px: 1'b1, exp_patches: 2 * NP, exp_done: 2};
    tbl[2] = '{frames: 3, vpct: 70, rpct: 40,  rand_px: 1'b1, exp_patches: 3 * NP, exp_done: 3};

    rst = 1'b1;
    bus.PIX_VALID   = 1'b0;
    bus.PIX_DATA    = '0;
    bus.PATCH_READY = 1'b0;
    clear_stats();
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst = 1'b0;
    set_ready(100);

    // Single frame 0..15, no stalls: latency and first-patch contents.
    clear_stats();
    fill_px(1, 1'b0, 0);
    model_stream();
    send_stream(100);
    drain();
    check_int("t1_patches", n_patch, NP);
    check_int("t1_frame_done", n_done, 1);
    check_vec("t1_first_patch", first_patch, pk9(0));
    if (acc_cyc.size() > 10) check_int("t1_latency", first_rise, acc_cyc[10]);
    else check_int("t1_accepts", acc_cyc.size(), W * H);
    $display("t1: patches=%0d frame_done=%0d first_rise=%0d", n_patch, n_done, first_rise);

    // Downstream stall of 5 cycles on the first patch.
    clear_stats();
    set_ready(0);
    fill_px(1, 1'b0, 0);
    model_stream();
    rise_cyc = 0;
    fork
      send_stream(100);
      begin
        int g = 0;
        while (!bus.PATCH_VALID && g < 300) begin
          @(negedge clk);
          g++;
        end
        check_int("t2_valid_seen", int'(g < 300), 1);
        for (int k = 0; k < 5; k++) begin
          if (k > 0) @(negedge clk);
          check_vec("t2_patch_stable", bus.PATCH, pk9(0));
          check_int("t2_pix_ready_low", int'(bus.PIX_READY), 0);
          check_int("t2_pixels_held", acc_cyc.size(), 11);
        end
        @(posedge clk); #1;
        rise_cyc = cyc;
        set_ready(100);
      end
    join
    drain();
    check_int("t2_patches", n_patch, NP);
    check_int("t2_frame_done", n_done, 1);
    if (acc_cyc.size() > 11) check_int("t2_pix11_after_ready", int'(acc_cyc[11] > rise_cyc), 1);
    else check_int("t2_accepts", acc_cyc.size(), W * H);
    $display("t2: patches=%0d frame_done=%0d ready_rise=%0d", n_patch, n_done, rise_cyc);

    // Two frames back-to-back, pixels 0..31.
    clear_stats();
    fill_px(2, 1'b0, 0);
    model_stream();
    send_stream(100);
    drain();
    check_int("t3_patches", n_patch, 2 * NP);
    check_int("t3_frame_done", n_done, 2);
    if (got_q.size() > NP) check_vec("t3_frame2_first", got_q[NP], pk9(16));
    $display("t3: patches=%0d frame_done=%0d", n_patch, n_done);

    // Randomized vector table.
    for (int t = 0; t < 3; t++) begin
      clear_stats();
      set_ready(tbl[t].rpct);
      fill_px(tbl[t].frames, tbl[t].rand_px, 0);
      model_stream();
      send_stream(tbl[t].vpct);
      set_ready(100);
      drain();
      check_int($sformatf("tbl%0d_patches", t), n_patch, tbl[t].exp_patches);
      check_int($sformatf("tbl%0d_frame_done", t), n_done, tbl[t].exp_done);
      $display("tbl%0d: frames=%0d vpct=%0d rpct=%0d patches=%0d frame_done=%0d",
               t, tbl[t].frames, tbl[t].vpct, tbl[t].rpct, n_patch, n_done);
    end

    // Reset after pixel 9, then a fresh frame 100..115.
    clear_stats();
    fill_px(1, 1'b0, 0);
    px_q = px_q[0:9];
    send_stream(100);
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    check_reset_outputs("midrst");
    @(posedge clk); #1;
    check_reset_outputs("midrst_hold");
    rst = 1'b0;
    clear_stats();
    fill_px(1, 1'b0, 100);
    model_stream();
    send_stream(100);
    drain();
    check_int("t4_patches", n_patch, NP);
    check_int("t4_frame_done", n_done, 1);
    check_vec("t4_first_patch", first_patch, pk9(100));
    $display("t4: patches=%0d frame_done=%0d", n_patch, n_done);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
